// File: rtl/temp_bcd_encoder_pkg.sv
// Shared constants and FSM encoding for the signed binary to BCD temperature encoder.
package temp_bcd_encoder_pkg;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_DIGITS     = 3;
  localparam int BCD_W          = BCD_DIGIT_W * BCD_DIGITS;
  localparam int ADD3_THRESHOLD = 5;
  localparam int MAX_WIDTH      = 10;
  localparam int CNT_W          = $clog2(MAX_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/temp_bcd_encoder_add3.sv
// Double-dabble digit adjust: a BCD digit of 5 or more gets 3 added before the next shift.
module bcd_add3
  import temp_bcd_encoder_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);

  assign d_o = (d_i >= BCD_DIGIT_W'(ADD3_THRESHOLD)) ? d_i + BCD_DIGIT_W'(3) : d_i;

endmodule

// File: rtl/temp_bcd_encoder.sv
// Converts a two's-complement temperature sample to sign plus three BCD digits,
// one double-dabble step per cycle, and holds the result until the next conversion.
module temp_bcd_encoder
  import temp_bcd_encoder_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_temp,
  output logic             busy,
  output logic             out_valid,
  output logic [3:0]       temp_value_ones,
  output logic [3:0]       temp_value_tens,
  output logic [3:0]       temp_value_huns,
  output logic             temp_value_sign,
  output logic             overrun
);

  if (WIDTH < 4 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("temp_bcd_encoder: WIDTH must be in 4..10");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   scratch_adj;
  logic               sign_cap_q, sign_cap_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic               sign_q, sign_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;
  logic [WIDTH-1:0]   in_mag;
  logic               accept;

  // -2^(WIDTH-1) negates to itself, which read unsigned is exactly 2^(WIDTH-1).
  assign in_mag = in_temp[WIDTH-1] ? (~in_temp + 1'b1) : in_temp;

  genvar gi;
  for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i(scratch_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_o(scratch_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign busy   = (state_q == ST_SHIFT);
  // The DONE cycle also accepts, so samples can follow each other every WIDTH+1 cycles.
  assign accept = in_valid && !busy;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    scratch_d   = scratch_q;
    sign_cap_d  = sign_cap_q;
    digits_d    = digits_q;
    sign_d      = sign_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q | (in_valid & busy);

    if (accept) begin
      sign_cap_d = in_temp[WIDTH-1];
      mag_d      = in_mag;
      scratch_d  = '0;
      cnt_d      = CNT_W'(WIDTH);
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        {scratch_d, mag_d} = {scratch_adj, mag_q} << 1;
        cnt_d              = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        digits_d    = scratch_q;
        sign_d      = sign_cap_q;
        out_valid_d = 1'b1;
        state_d     = in_valid ? ST_SHIFT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mag_q       <= '0;
      scratch_q   <= '0;
      sign_cap_q  <= 1'b0;
      digits_q    <= '0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      scratch_q   <= scratch_d;
      sign_cap_q  <= sign_cap_d;
      digits_q    <= digits_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign temp_value_ones = digits_q[3:0];
  assign temp_value_tens = digits_q[7:4];
  assign temp_value_huns = digits_q[11:8];
  assign temp_value_sign = sign_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_temp_bcd_encoder.sv
// Directed bench for temp_bcd_encoder with a scoreboard of expected results per instance.
module tb_temp_bcd_encoder;

  typedef struct {
    logic [12:0] val;
    int          acc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       iv10, iv8;
  logic [9:0] t10;
  logic [7:0] t8;
  logic       busy10, ov10, sg10, orun10;
  logic [3:0] o10, te10, h10;
  logic       busy8, ov8, sg8, orun8;
  logic [3:0] o8, te8, h8;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q10[$];
  exp_t q8[$];

  temp_bcd_encoder #(.WIDTH(10)) dut10 (
    .clk(clk), .rst(rst), .in_valid(iv10), .in_temp(t10),
    .busy(busy10), .out_valid(ov10),
    .temp_value_ones(o10), .temp_value_tens(te10), .temp_value_huns(h10),
    .temp_value_sign(sg10), .overrun(orun10)
  );

  temp_bcd_encoder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_temp(t8),
    .busy(busy8), .out_valid(ov8),
    .temp_value_ones(o8), .temp_value_tens(te8), .temp_value_huns(h8),
    .temp_value_sign(sg8), .overrun(orun8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference conversion by decimal arithmetic on the signed value.
  function automatic logic [12:0] model(input int raw, input int w);
    int   v;
    int   m;
    logic s;
    v = raw;
    if (raw >= (1 << (w - 1))) v = raw - (1 << w);
    s = (v < 0);
    m = s ? -v : v;
    return {s, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic push_exp(input bit w8, input int raw, input int acc);
    exp_t e;
    e.val = model(raw, w8 ? 8 : 10);
    e.acc = acc;
    if (w8) q8.push_back(e);
    else q10.push_back(e);
  endtask

  task automatic send(input bit w8, input int raw, input bit push);
    @(negedge clk);
    if (w8) begin
      iv8 = 1'b1;
      t8  = raw[7:0];
    end else begin
      iv10 = 1'b1;
      t10  = raw[9:0];
    end
    if (push) push_exp(w8, raw, cyc + 1);
    @(negedge clk);
    iv8  = 1'b0;
    iv10 = 1'b0;
    repeat ((w8 ? 8 : 10) - 1) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q10.size() + q8.size()) != 0; i++) @(negedge clk);
    check("drain_pending", q10.size() + q8.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ov10 === 1'b1) begin
      if (q10.size() == 0) begin
        check("unexpected_out_valid10", 1, 0);
      end else begin
        e = q10.pop_front();
        check("result10", {sg10, h10, te10, o10}, e.val);
        check("latency10", cyc - e.acc, 11);
        $display("w10 result sign=%0d %0d%0d%0d", sg10, h10, te10, o10);
      end
    end
    if (ov8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("unexpected_out_valid8", 1, 0);
      end else begin
        e = q8.pop_front();
        check("result8", {sg8, h8, te8, o8}, e.val);
        check("latency8", cyc - e.acc, 9);
        $display("w8 result sign=%0d %0d%0d%0d", sg8, h8, te8, o8);
      end
    end
  end

  initial begin
    int bc;
    rst  = 1'b0;
    iv10 = 1'b0;
    iv8  = 1'b0;
    t10  = '0;
    t8   = '0;

    repeat (3) @(negedge clk);
    check("reset_digits", {sg10, h10, te10, o10}, 13'h0);
    check("reset_busy", busy10, 0);
    check("reset_out_valid", ov10, 0);
    check("reset_overrun", orun10, 0);
    check("reset_digits8", {sg8, h8, te8, o8}, 13'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Zero input and busy duration.
    @(negedge clk);
    iv10 = 1'b1;
    t10  = 10'd0;
    push_exp(1'b0, 0, cyc + 1);
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      iv10 = 1'b0;
      if (busy10 !== 1'b1) break;
      bc++;
    end
    check("busy_cycles", bc, 10);
    drain();

    // Extremes and mixed values, back to back.
    send(1'b0, 511, 1'b1);
    send(1'b0, 1023, 1'b1);
    send(1'b0, 512, 1'b1);
    send(1'b0, 1024 - 300, 1'b1);
    drain();

    for (int v = 0; v < 1024; v++) send(1'b0, v, 1'b1);
    drain();
    check("overrun_after_sweep", orun10, 0);

    // Held strobe: only every 11th sample is taken, the rest raise overrun.
    for (int i = 0; i < 30; i++) begin
      int r;
      @(negedge clk);
      if (i == 2) check("overrun_set_early", orun10, 1);
      r    = int'($urandom_range(0, 1023));
      iv10 = 1'b1;
      t10  = r[9:0];
      if (i % 11 == 0) push_exp(1'b0, r, cyc + 1);
    end
    @(negedge clk);
    iv10 = 1'b0;
    check("overrun_sticky", orun10, 1);
    drain();
    check("overrun_still_set", orun10, 1);

    // Reset during a conversion aborts it.
    @(negedge clk);
    iv10 = 1'b1;
    t10  = 10'd123;
    @(negedge clk);
    iv10 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_digits", {sg10, h10, te10, o10}, 13'h0);
    check("abort_busy", busy10, 0);
    check("abort_out_valid", ov10, 0);
    check("abort_overrun", orun10, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    send(1'b0, 123, 1'b1);
    drain();

    // Narrow instance.
    send(1'b1, 128, 1'b1);
    send(1'b1, 127, 1'b1);
    send(1'b1, 256 - 5, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
